aes_out_buffer: RTL
===================

AES_OUT_BUFFER -- requirements
Module: aes_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 128-bit result entries; legal values 2..16, powers of two only.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port issue  input  1  one-cycle pulse; one block has been started into the encrypt engine.
REQ-005 SHALL have port in_data  input  128  ciphertext from the encrypt engine.
REQ-006 SHALL have port in_valid  input  1  in_data valid; the engine cannot be stalled.
REQ-007 SHALL have port flush  input  1  discard buffered and in-flight results; paired with engine halt.
REQ-008 SHALL have port out_data  output  128  head-of-queue ciphertext.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts; pop when out_valid && out_ready.
REQ-011 SHALL have port credit_ok  output  1  upstream may issue another block.
REQ-012 SHALL have port count  output  5  entries stored.
REQ-013 SHALL have port inflight  output  5  issued blocks not yet returned (excludes discards).
REQ-014 SHALL have port err  output  3  sticky errors {underflow, overflow, issue_err}, bits [2:0].
REQ-015 SHALL have port err_clr  input  1  clear all err bits.

Function
REQ-016 SHALL implement a circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-017 SHALL present the head entry first-word-fall-through: out_valid = (count != 0); out_data = entry at read pointer.
REQ-018 SHALL make a pushed entry visible on out_valid the cycle after in_valid; one-cycle latency when empty.
REQ-019 SHALL drive credit_ok = (count + inflight) < DEPTH, decoded combinationally from registers only.
REQ-020 SHALL increment inflight on issue, saturating at 31; on issue with credit_ok=0 it SHALL also set err[0] and still count.
REQ-021 SHALL maintain an internal discard counter (5 bits, not a port).
REQ-022 On in_valid without flush: if discard>0, drop data and decrement discard; else if inflight>0, push and decrement inflight; else push and set err[2] (underflow).
REQ-023 Issue and a matched in_valid in the same cycle SHALL leave inflight unchanged.
REQ-024 A push while full SHALL drop the data and set err[1], unless a pop occurs the same cycle, in which case both occur and count is unchanged.
REQ-025 Pop and push in the same cycle on a non-full FIFO SHALL leave count unchanged and advance both pointers.
REQ-026 On flush, SHALL set count to 0 and reset both pointers to 0; out_valid SHALL be 0 next cycle.
REQ-027 On flush, SHALL set discard to min(31, discard + inflight - in_valid), floor 0, and set inflight to 0; any in_valid that cycle is dropped.
REQ-028 Issue coinciding with flush SHALL be counted as post-flush: inflight becomes 1.
REQ-029 A pop coinciding with flush SHALL be ignored.
REQ-030 err_clr SHALL clear err; an error raised the same cycle SHALL win (bit set).

Reset
REQ-031 On rst_n low, SHALL asynchronously set count=0, inflight=0, discard=0, pointers=0, err=0, out_valid=0, credit_ok=1.
REQ-032 Storage array contents SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-033 Reset mid-operation SHALL drop all entries and counters; any in_valid after release with inflight=0 SHALL be treated per REQ-022 (underflow).

Verification
REQ-034 Issue 3 pulses, then in_valid with A, B, C, out_ready=1 -> out_data order A,B,C; inflight 3->0; err=0.
REQ-035 out_ready=0, 16 issues, 16 returns -> count=16, credit_ok=0 after 16th issue; 17th issue -> err[0]=1, inflight=1.
REQ-036 Full FIFO, in_valid with out_ready=1 same cycle -> count stays 16, no err[1]; without pop -> err[1]=1, data dropped.
REQ-037 4 issued, 2 returned, flush -> count=0, inflight=0, discard=2; next 2 in_valid dropped; a 3rd issue+return is stored with out_valid=1.
REQ-038 in_valid with inflight=0 -> err[2]=1, data stored; err_clr -> err=0 next cycle.
REQ-039 Assert rst_n low with count=5, inflight=3 -> all outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/aes_out_buffer.sv
// Result buffer between a non-stallable AES encrypt engine and its consumer.
// Tracks issued-but-unreturned blocks so upstream only issues when a slot is guaranteed.
module aes_out_buffer #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  input  logic         flush,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         credit_ok,
  output logic [4:0]   count,
  output logic [4:0]   inflight,
  output logic [2:0]   err,
  input  logic         err_clr
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [127:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [4:0]       discard;

  logic       full;
  logic       pop;
  logic       accept;
  logic       matched;
  logic       push;
  logic       overflow;
  logic       underflow;
  logic       issue_err;
  logic [5:0] occupancy;
  logic [5:0] flush_sum;
  logic [4:0] flush_discard;

  assign out_valid = (count != 5'd0);
  assign out_data  = mem[rd_ptr];

  // Results arriving while discard is nonzero belong to blocks issued before a flush.
  always_comb begin
    full      = (count == DEPTH_C);
    occupancy = {1'b0, count} + {1'b0, inflight};
    credit_ok = (occupancy < 6'(DEPTH));
    pop       = out_valid && out_ready && !flush;
    accept    = in_valid && !flush && (discard == 5'd0);
    matched   = accept && (inflight != 5'd0);
    underflow = accept && (inflight == 5'd0);
    push      = accept && (!full || pop);
    overflow  = accept && full && !pop;
    issue_err = issue && !credit_ok;

    flush_sum = {1'b0, discard} + {1'b0, inflight};
    if (in_valid && (flush_sum != 6'd0)) begin
      flush_sum = flush_sum - 6'd1;
    end
    flush_discard = (flush_sum > 6'd31) ? 5'd31 : flush_sum[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 5'd0;
      inflight <= 5'd0;
      discard  <= 5'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      err      <= 3'b000;
    end else begin
      err <= (err_clr ? 3'b000 : err) | {underflow, overflow, issue_err};

      if (flush) begin
        count    <= 5'd0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        discard  <= flush_discard;
        inflight <= issue ? 5'd1 : 5'd0;
      end else begin
        if (push && !pop) begin
          count <= count + 5'd1;
        end else if (pop && !push) begin
          count <= count - 5'd1;
        end

        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end

        if (in_valid && (discard != 5'd0)) begin
          discard <= discard - 5'd1;
        end

        // An issue and a matched return in the same cycle cancel out.
        if (issue && !matched) begin
          if (inflight != 5'd31) begin
            inflight <= inflight + 5'd1;
          end
        end else if (matched && !issue) begin
          inflight <= inflight - 5'd1;
        end
      end
    end
  end

  // Storage needs no reset; out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule
